// File: rtl/led_fill_drain_seq.sv
// led_fill_drain_seq: serial fill/hold/drain/hold pattern generator for a downstream SIPO LED register.
module led_fill_drain_seq #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 25000000,
  parameter int HOLD_STEPS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  output logic                       s_out,
  output logic                       shift_tick,
  output logic [$clog2(WIDTH+1)-1:0] level,
  output logic [1:0]                 phase
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
  localparam logic [LW-1:0] LMAX = LW'(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_STEPS > 0 ? HOLD_STEPS - 1 : 0);
  localparam bit NO_HOLD = HOLD_STEPS == 0;
  typedef enum logic [1:0] {FILL, HOLD_FULL, DRAIN, HOLD_EMPTY} phase_t;
  phase_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [LW-1:0] level_n;
  logic s_n, tick_n, step;
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= FILL;
      cnt        <= '0;
      hcnt       <= '0;
      level      <= '0;
      s_out      <= 1'b0;
      shift_tick <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      hcnt       <= hcnt_n;
      level      <= level_n;
      s_out      <= s_n;
      shift_tick <= tick_n;
    end
  end
  always_comb begin
    step    = run && cnt == CMAX;
    cnt_n   = !run ? cnt : step ? '0 : cnt + CW'(1);
    st_n    = st;
    hcnt_n  = hcnt;
    level_n = level;
    s_n     = s_out;
    tick_n  = 1'b0;
    if (level > LMAX) begin
      st_n    = FILL;
      level_n = '0;
      s_n     = 1'b0;
      hcnt_n  = '0;
    end else if (step) begin
      case (st)
        FILL: begin
          tick_n  = 1'b1;
          s_n     = 1'b1;
          level_n = level + LW'(1);
          if (level == LMAX - LW'(1)) st_n = NO_HOLD ? DRAIN : HOLD_FULL;
        end
        DRAIN: begin
          tick_n  = 1'b1;
          s_n     = 1'b0;
          level_n = level - LW'(1);
          if (level == LW'(1)) st_n = NO_HOLD ? FILL : HOLD_EMPTY;
        end
        default: begin
          hcnt_n = hcnt == HMAX ? '0 : hcnt + HW'(1);
          if (hcnt == HMAX) st_n = st == HOLD_FULL ? DRAIN : FILL;
        end
      endcase
    end
  end
  assign phase = st;
endmodule
